// File: rtl/clock_display_driver.sv
// Packed h:m:s word to a 6-digit multiplexed 7-segment display.
// Sequential BCD conversion feeds a double-buffered display register.
module clock_display_driver #(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [1:0]  fmt,
  input  logic [16:0] din,
  output logic        busy,
  output logic        err,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state_q;
  logic [1:0]       fld_q;
  logic [2:0]       sub_q;
  logic [5:0]       v_q;
  logic [2:0]       tens_q;
  logic [5:0]       m_q, s_q;
  logic             pm_pend_q, err_pend_q;
  logic [3:0][3:0]  wbuf_q;
  logic [5:0][3:0]  dbuf_q;
  logic             pm_q, err_q, busy_q;
  logic [15:0]      cnt_q;
  logic [2:0]       idx_q;

  logic       is12;
  logic [4:0] h_raw, h_sel;
  logic [3:0] h12;
  logic [5:0] m_raw, s_raw;
  logic       err_in;

  assign is12  = (fmt == 2'b01);
  assign h_raw = din[16:12];
  assign h12   = din[15:12];
  assign m_raw = din[11:6];
  assign s_raw = din[5:0];
  // 12h mode shows midnight/noon hour 0 as 12
  assign h_sel = is12 ? ((h12 == 4'd0) ? 5'd12 : {1'b0, h12}) : h_raw;

  always_comb begin
    err_in = 1'b0;
    case (fmt)
      2'b01:   err_in = (h12 > 4'd11) || (m_raw > 6'd59) || (s_raw > 6'd59);
      // a 5-bit day can never exceed 31, only zero is illegal
      2'b10:   err_in = (h_raw == 5'd0) || (m_raw == 6'd0) || (m_raw > 6'd12);
      default: err_in = (h_raw > 5'd23) || (m_raw > 6'd59) || (s_raw > 6'd59);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fld_q      <= '0;
      sub_q      <= '0;
      v_q        <= '0;
      tens_q     <= '0;
      m_q        <= '0;
      s_q        <= '0;
      pm_pend_q  <= 1'b0;
      err_pend_q <= 1'b0;
      wbuf_q     <= '0;
      dbuf_q     <= '0;
      pm_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (load) begin
          state_q    <= CONV;
          busy_q     <= 1'b1;
          fld_q      <= 2'd0;
          sub_q      <= 3'd0;
          v_q        <= {1'b0, h_sel};
          tens_q     <= 3'd0;
          m_q        <= m_raw;
          s_q        <= s_raw;
          pm_pend_q  <= is12 & din[16];
          err_pend_q <= err_in;
        end
        CONV: begin
          if (sub_q != 3'd6) begin
            if (v_q >= 6'd10) begin
              v_q    <= v_q - 6'd10;
              tens_q <= tens_q + 3'd1;
            end
            sub_q <= sub_q + 3'd1;
          end else begin
            tens_q <= 3'd0;
            sub_q  <= 3'd0;
            fld_q  <= fld_q + 2'd1;
            case (fld_q)
              2'd0: begin
                wbuf_q[3] <= {1'b0, tens_q};
                wbuf_q[2] <= v_q[3:0];
                v_q       <= m_q;
              end
              2'd1: begin
                wbuf_q[1] <= {1'b0, tens_q};
                wbuf_q[0] <= v_q[3:0];
                v_q       <= s_q;
              end
              default: begin
                // S digits bypass the working buffer so the commit is a single edge
                dbuf_q  <= {wbuf_q[3], wbuf_q[2], wbuf_q[1], wbuf_q[0],
                            {1'b0, tens_q}, v_q[3:0]};
                pm_q    <= pm_pend_q;
                err_q   <= err_pend_q;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == 16'(REFRESH_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  logic [3:0] digit;

  always_comb begin
    digit = 4'd0;
    case (idx_q)
      3'd0: digit = dbuf_q[0];
      3'd1: digit = dbuf_q[1];
      3'd2: digit = dbuf_q[2];
      3'd3: digit = dbuf_q[3];
      3'd4: digit = dbuf_q[4];
      3'd5: digit = dbuf_q[5];
      default: digit = 4'd0;
    endcase
  end

  always_comb begin
    seg = 7'b0000000;
    case (digit)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end

  assign an   = 6'd1 << idx_q;
  assign dp   = (idx_q == 3'd2) || (idx_q == 3'd4) || ((idx_q == 3'd0) && pm_q);
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Scoreboard bench for clock_display_driver: stimulus pushes expected display
// contents, a monitor checks them whenever a conversion completes.
module tb_clock_display_driver;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [1:0]  fmt;
  logic [16:0] din;
  logic        busy, err, dp;
  logic [5:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  clock_display_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .fmt(fmt), .din(din),
    .busy(busy), .err(err), .an(an), .seg(seg), .dp(dp)
  );

  typedef struct {
    logic [23:0] d;   // six BCD digits, leftmost in the top nibble
    logic        e;
    logic        p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] segtab(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B;
      4'd3: return 7'h4F; 4'd4: return 7'h66; 4'd5: return 7'h6D;
      4'd6: return 7'h7D; 4'd7: return 7'h07; 4'd8: return 7'h7F;
      4'd9: return 7'h6F; default: return 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] dig(input logic [23:0] d, input int k);
    return d[k*4 +: 4];
  endfunction

  // Called from a negedge: walks the scan and checks every digit position.
  task automatic check_display(input logic [23:0] d, input logic pm, input string tag);
    for (int j = 0; j < 6; j++)
      if (an == (6'd1 << j)) chk({tag, "_first_seg"}, int'(seg), int'(segtab(dig(d, j))));
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      while (an != (6'd1 << k) && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) chk($sformatf("%s_scan_timeout%0d", tag, k), 0, 1);
      else begin
        chk($sformatf("%s_seg%0d", tag, k), int'(seg), int'(segtab(dig(d, k))));
        chk($sformatf("%s_dp%0d", tag, k), int'(dp),
            int'((k == 2) || (k == 4) || (k == 0 && pm)));
      end
    end
  endtask

  // Monitor: busy falling outside reset marks a committed result
  initial begin
    int   blen = 0;
    logic pb = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 1'b0;
        blen = 0;
      end else begin
        if (busy) blen++;
        if (pb && !busy) begin
          chk("busy_len", blen, 21);
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("err", int'(err), int'(e.e));
            check_display(e.d, e.p, "disp");
          end
          done_cnt++;
        end
        pb = busy;
        if (!busy) blen = 0;
      end
    end
  end

  // Scan checker: each an value held 4 cycles, rotating left
  initial begin
    logic [5:0] pa = 6'd1;
    int run = 0;
    bit valid = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pa = an; run = 0; valid = 0;
      end else if (an == pa) begin
        run++;
      end else begin
        if (valid) chk("scan_hold", run, 4);
        chk("scan_step", int'(an), int'({pa[4:0], pa[5]}));
        valid = 1; run = 1; pa = an;
      end
    end
  end

  task automatic pulse_load(input logic [1:0] f, input logic [16:0] w);
    fmt = f; din = w; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk("done_timeout", 0, 1);
  endtask

  task automatic convert(input logic [1:0] f, input logic [16:0] w,
                         input logic [23:0] d, input logic e, input logic p);
    int d0 = done_cnt;
    sb.push_back('{d: d, e: e, p: p});
    pulse_load(f, w);
    wait_done(d0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; load = 1'b0; fmt = 2'b00; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_an", int'(an), 1);
    chk("rst_seg", int'(seg), 7'h3F);
    chk("rst_dp", int'(dp), 0);
    @(posedge clk); #1;

    convert(2'b00, 17'h0DB47, 24'h134507, 1'b0, 1'b0);
    convert(2'b01, 17'h11000, 24'h010000, 1'b0, 1'b1);
    convert(2'b01, 17'h00780, 24'h123000, 1'b0, 1'b0);
    convert(2'b10, 17'h1D098, 24'h290224, 1'b0, 1'b0);
    convert(2'b10, 17'h00080, 24'h000200, 1'b1, 1'b0);

    // second load 5 cycles into a conversion must be dropped
    d0 = done_cnt;
    sb.push_back('{d: 24'h134507, e: 1'b0, p: 1'b0});
    pulse_load(2'b00, 17'h0DB47);
    repeat (4) @(posedge clk);
    #1 pulse_load(2'b01, 17'h11000);
    wait_done(d0);

    convert(2'b00, 17'h18F00, 24'h246000, 1'b1, 1'b0);

    // reset 10 cycles into a conversion discards it
    pulse_load(2'b01, 17'h11000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_an", int'(an), 1);
    chk("abort_seg", int'(seg), 7'h3F);
    check_display(24'h000000, 1'b0, "abort");
    repeat (40) @(negedge clk);
    chk("abort_no_commit", done_cnt, 7);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
